// File: rtl/perspective_transform_arbiter_pkg.sv
// Shared types for the perspective transform arbiter.
// Result records carry the requester id with the transformed pair.
package pt_arb_pkg;

    localparam int COORD_W  = 11;
    localparam int ID_MAX_W = 3;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ID_W = id_w(4);

    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic [COORD_W-1:0]  x;
        logic [COORD_W-1:0]  y;
    } pt_result_t;

endpackage

// File: rtl/perspective_transform_arbiter_if.sv
// Bus bundle between requesters, the transform and the result consumer.
interface perspective_transform_arbiter_if
    import pt_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = id_w(N_REQ)
);
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ*COORD_W-1:0] req_x;
    logic [N_REQ*COORD_W-1:0] req_y;
    logic [N_REQ-1:0]         req_ready;
    logic [COORD_W-1:0]       xf_x_coord;
    logic [COORD_W-1:0]       xf_y_coord;
    logic [COORD_W-1:0]       xf_x_adj;
    logic [COORD_W-1:0]       xf_y_adj;
    logic                     out_valid;
    logic                     out_ready;
    logic [IW-1:0]            out_id;
    logic [COORD_W-1:0]       out_x;
    logic [COORD_W-1:0]       out_y;
    logic                     busy;

    modport slave (
        input  req_valid, req_x, req_y, xf_x_adj, xf_y_adj, out_ready,
        output req_ready, xf_x_coord, xf_y_coord,
        output out_valid, out_id, out_x, out_y, busy
    );

    modport master (
        output req_valid, req_x, req_y, xf_x_adj, xf_y_adj, out_ready,
        input  req_ready, xf_x_coord, xf_y_coord,
        input  out_valid, out_id, out_x, out_y, busy
    );
endinterface

// File: rtl/perspective_transform_arbiter_fifo.sv
// Show-ahead result FIFO; head entry is visible while not empty.
module pt_result_fifo
    import pt_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  pt_result_t             din,
    input  logic                   pop,
    output pt_result_t             dout,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    pt_result_t      mem_q [DEPTH];
    logic [AW-1:0]   wp_q, wp_d;
    logic [AW-1:0]   rp_q, rp_d;
    logic [AW:0]     cnt_q, cnt_d;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (push) wp_d = wp_q + 1'b1;
        if (pop)  rp_d = rp_q + 1'b1;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= din;
    end

    assign dout  = mem_q[rp_q];
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
endmodule

// File: rtl/perspective_transform_arbiter.sv
// Round-robin share of one transform datapath with id tagging and
// a credit-protected result FIFO.
module perspective_transform_arbiter
    import pt_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int XF_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
) (
    input logic clk,
    input logic reset,
    perspective_transform_arbiter_if.slave bus
);
    localparam int IDW   = id_w(N_REQ);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int NST   = XF_LATENCY + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

    logic [IDW-1:0]     rr_q, rr_d;
    logic [NST-1:0]     tv_q, tv_d;
    logic [IDW-1:0]     tid_q [NST];
    logic [IDW-1:0]     tid_d [NST];
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;

    logic [CNT_W-1:0]   in_flight;
    logic [CNT_W-1:0]   fifo_cnt;
    logic               credit_ok;
    logic [N_REQ-1:0]   gnt;
    logic [IDW-1:0]     gid;
    logic               found;
    logic               issue;
    logic               push, pop, empty;
    pt_result_t         din, head;
    logic               unused_head;

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < NST; i++)
            in_flight = in_flight + CNT_W'(tv_q[i]);
    end

    // The final tag stage is this cycle's push, so it is counted once here
    assign credit_ok = ({1'b0, in_flight} + {1'b0, fifo_cnt}) < DEPTH_C;

    always_comb begin
        gnt   = '0;
        gid   = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && bus.req_valid[(int'(rr_q) + k) % N_REQ]) begin
                found = 1'b1;
                gid   = IDW'((int'(rr_q) + k) % N_REQ);
            end
        end
        if (found && credit_ok && !reset) gnt[gid] = 1'b1;
    end

    assign issue         = |gnt;
    assign bus.req_ready = gnt;

    always_comb begin
        rr_d     = issue ? gid : rr_q;
        x_d      = issue ? bus.req_x[gid*COORD_W +: COORD_W] : x_q;
        y_d      = issue ? bus.req_y[gid*COORD_W +: COORD_W] : y_q;
        tv_d     = {tv_q[NST-2:0], issue};
        tid_d[0] = gid;
        for (int i = 1; i < NST; i++) tid_d[i] = tid_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q <= IDW'(N_REQ - 1);
            tv_q <= '0;
            x_q  <= '0;
            y_q  <= '0;
            for (int i = 0; i < NST; i++) tid_q[i] <= '0;
        end else begin
            rr_q <= rr_d;
            tv_q <= tv_d;
            x_q  <= x_d;
            y_q  <= y_d;
            for (int i = 0; i < NST; i++) tid_q[i] <= tid_d[i];
        end
    end

    assign bus.xf_x_coord = x_q;
    assign bus.xf_y_coord = y_q;

    assign push = tv_q[NST-1];
    assign din  = '{id: ID_MAX_W'(tid_q[NST-1]),
                    x:  bus.xf_x_adj,
                    y:  bus.xf_y_adj};
    assign pop  = !empty && bus.out_ready;

    pt_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .dout  (head),
        .empty (empty),
        .count (fifo_cnt)
    );

    assign bus.out_valid = !empty;
    assign bus.out_id    = head.id[IDW-1:0];
    assign bus.out_x     = head.x;
    assign bus.out_y     = head.y;
    assign bus.busy      = (|tv_q) || !empty;
    assign unused_head   = ^head.id;
endmodule

// File: tb/tb_perspective_transform_arbiter.sv
// Directed bench with a queue-based model of grants, transforms and
// the result buffer, plus literal expectations per scenario.
module tb_perspective_transform_arbiter;
    import pt_arb_pkg::*;

    localparam int N  = 4;
    localparam int L  = 1;
    localparam int D  = 4;
    localparam int CW = COORD_W;

    typedef struct {
        int id;
        int x;
        int y;
        int cyc;
    } item_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    perspective_transform_arbiter_if #(.N_REQ(N)) bus ();

    perspective_transform_arbiter #(
        .N_REQ(N), .XF_LATENCY(L), .FIFO_DEPTH(D)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Transform stand-in: one-edge latency, adds 1000 mod 2048
    always @(posedge clk) begin
        bus.xf_x_adj <= bus.xf_x_coord + 11'd1000;
        bus.xf_y_adj <= bus.xf_y_coord + 11'd1000;
    end

    int nerr = 0;
    int nchk = 0;
    int cyc = 0;
    bit chk_en = 0;
    bit oneshot = 0;
    logic [N-1:0] rv;
    int cx [N];
    int cy [N];

    item_t pend [$];
    item_t fq [$];
    int rr_m;
    int lx, ly;

    int gnt_log [$];
    int gnt_cyc [$];
    item_t pop_log [$];

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        logic [N-1:0] er;
        int g;
        bit ev;
        item_t it;
        bus.req_valid = rv;
        for (int i = 0; i < N; i++) begin
            bus.req_x[i*CW +: CW] = CW'(cx[i]);
            bus.req_y[i*CW +: CW] = CW'(cy[i]);
        end
        #1;
        er = '0;
        g  = -1;
        if (!reset && (pend.size() + fq.size()) < D)
            for (int k = 1; k <= N; k++)
                if (g < 0 && rv[(rr_m + k) % N]) g = (rr_m + k) % N;
        if (g >= 0) er[g] = 1'b1;
        ev = fq.size() > 0;
        if (chk_en) begin
            chk("req_ready", int'(bus.req_ready), int'(er));
            chk("out_valid", int'(bus.out_valid), int'(ev));
            chk("busy", int'(bus.busy),
                int'(pend.size() > 0 || fq.size() > 0));
            chk("xf_x_coord", int'(bus.xf_x_coord), lx);
            chk("xf_y_coord", int'(bus.xf_y_coord), ly);
            if (ev) begin
                chk("out_id", int'(bus.out_id), fq[0].id);
                chk("out_x", int'(bus.out_x), fq[0].x);
                chk("out_y", int'(bus.out_y), fq[0].y);
            end
        end
        for (int i = 0; i < N; i++)
            if (bus.req_ready[i]) begin
                gnt_log.push_back(i);
                gnt_cyc.push_back(cyc);
            end
        if (bus.out_valid && bus.out_ready)
            pop_log.push_back('{int'(bus.out_id), int'(bus.out_x),
                                int'(bus.out_y), cyc});
        if (reset) begin
            pend.delete();
            fq.delete();
            rr_m = N - 1;
            lx = 0;
            ly = 0;
        end else begin
            if (ev && bus.out_ready) void'(fq.pop_front());
            while (pend.size() > 0 && pend[0].cyc == cyc) begin
                it = pend.pop_front();
                fq.push_back('{it.id, (it.x + 1000) % 2048,
                               (it.y + 1000) % 2048, 0});
            end
            if (chk_en) chk("fifo_no_overflow", int'(fq.size() <= D), 1);
            if (g >= 0) begin
                pend.push_back('{g, cx[g], cy[g], cyc + L + 1});
                rr_m = g;
                lx = cx[g];
                ly = cy[g];
                if (oneshot) rv[g] = 1'b0;
            end
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rv = '0;
        step();
        reset = 1'b0;
        chk_en = 1'b1;
        gnt_log.delete();
        gnt_cyc.delete();
        pop_log.delete();
    endtask

    int ex [N] = '{1370, 1020, 1630, 1260};
    int ey [N] = '{1310, 1470, 1470, 1360};
    int t0;

    initial begin
        reset = 1'b1;
        rv = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            cx[i] = 0;
            cy[i] = 0;
        end
        rr_m = N - 1;
        lx = 0;
        ly = 0;
        @(negedge clk);
        do_reset();

        // single request
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_busy", int'(bus.busy), 0);
        oneshot = 1;
        cx[0] = 280; cy[0] = 310;
        rv = 4'b0001;
        steps(8);
        chk("t1_grants", gnt_log.size(), 1);
        chk("t1_gnt_id", gnt_log.size() > 0 ? gnt_log[0] : -1, 0);
        chk("t1_pops", pop_log.size(), 1);
        if (pop_log.size() > 0 && gnt_cyc.size() > 0) begin
            chk("t1_id", pop_log[0].id, 0);
            chk("t1_x", pop_log[0].x, 1280);
            chk("t1_y", pop_log[0].y, 1310);
            chk("t1_latency", pop_log[0].cyc - gnt_cyc[0], 3);
        end

        // all requesters continuous
        do_reset();
        oneshot = 0;
        cx[0] = 370; cy[0] = 310;
        cx[1] = 20;  cy[1] = 470;
        cx[2] = 630; cy[2] = 470;
        cx[3] = 260; cy[3] = 360;
        rv = 4'b1111;
        steps(12);
        rv = '0;
        steps(6);
        chk("t2_grants", gnt_log.size(), 12);
        chk("t2_pops", pop_log.size(), 12);
        if (gnt_log.size() == 12 && pop_log.size() == 12) begin
            for (int i = 0; i < 8; i++) chk("t2_gnt_order", gnt_log[i], i % 4);
            for (int i = 0; i < 12; i++) chk("t2_pop_id", pop_log[i].id, i % 4);
            for (int i = 0; i < 4; i++) begin
                chk("t2_x", pop_log[i].x, ex[i]);
                chk("t2_y", pop_log[i].y, ey[i]);
            end
            chk("t2_gnt_rate", gnt_cyc[11] - gnt_cyc[0], 11);
            chk("t2_pop_rate", pop_log[11].cyc - pop_log[0].cyc, 11);
        end

        // backpressure
        do_reset();
        bus.out_ready = 1'b0;
        rv = 4'b1111;
        steps(10);
        chk("t3_grants_held", gnt_log.size(), 4);
        chk("t3_head_id", int'(bus.out_id), 0);
        chk("t3_head_x", int'(bus.out_x), 1370);
        step();
        chk("t3_head_y_stable", int'(bus.out_y), 1310);
        bus.out_ready = 1'b1;
        steps(10);
        rv = '0;
        steps(6);
        chk("t3_resumed", int'(gnt_log.size() > 4), 1);
        if (pop_log.size() >= 4 && gnt_log.size() > 4) begin
            for (int i = 0; i < 4; i++) chk("t3_drain_id", pop_log[i].id, i);
            chk("t3_next_gnt", gnt_log[4], 0);
        end

        // FIFO at 3 with a capture arriving while popping
        do_reset();
        bus.out_ready = 1'b0;
        rv = 4'b1111;
        steps(5);
        bus.out_ready = 1'b1;
        steps(8);
        rv = '0;
        steps(6);
        chk("t4_balance", pop_log.size(), gnt_log.size());
        for (int i = 0; i < pop_log.size() && i < 8; i++)
            chk("t4_pop_id", pop_log[i].id, i % 4);

        // reset mid-operation
        do_reset();
        bus.out_ready = 1'b0;
        rv = 4'b1111;
        steps(4);
        chk("t5_pre_valid", int'(bus.out_valid), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        rv = '0;
        #1;
        chk("t5_post_valid", int'(bus.out_valid), 0);
        chk("t5_post_busy", int'(bus.busy), 0);
        gnt_log.delete();
        gnt_cyc.delete();
        pop_log.delete();
        bus.out_ready = 1'b1;
        rv = 4'b1111;
        steps(8);
        rv = '0;
        steps(6);
        chk("t5_first_gnt", gnt_log.size() > 0 ? gnt_log[0] : -1, 0);
        chk("t5_no_stale", pop_log.size(), gnt_log.size());

        // sparse requests
        do_reset();
        oneshot = 1;
        cx[2] = 100; cy[2] = 420;
        rv = 4'b0100;
        t0 = cyc;
        step();
        steps(4);
        cx[2] = 500;
        rv = 4'b0100;
        steps(8);
        chk("t6_grants", gnt_log.size(), 2);
        chk("t6_pops", pop_log.size(), 2);
        if (gnt_log.size() == 2 && pop_log.size() == 2) begin
            chk("t6_immediate", gnt_cyc[0], t0);
            chk("t6_spacing", gnt_cyc[1] - gnt_cyc[0], 5);
            chk("t6_id0", pop_log[0].id, 2);
            chk("t6_x0", pop_log[0].x, 1100);
            chk("t6_y0", pop_log[0].y, 1420);
            chk("t6_id1", pop_log[1].id, 2);
            chk("t6_x1", pop_log[1].x, 1500);
            chk("t6_y1", pop_log[1].y, 1420);
        end
        chk("t6_idle_busy", int'(bus.busy), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
